// File: rtl/data_mem_sized_if.sv
// Load/store bus between the datapath load/store unit and data_mem_sized.
// The datapath is the master; the memory is the slave.
interface data_mem_sized_if;
    logic [31:0] address;
    logic [31:0] memIn;
    logic        read;
    logic        write;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] memOut;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output address, memIn, read, write, size, unsigned_ld,
        input  memOut, busy, done, error
    );

    modport slave (
        input  address, memIn, read, write, size, unsigned_ld,
        output memOut, busy, done, error
    );
endinterface

// File: rtl/data_mem_sized.sv
// Byte/half/word data memory with alignment and range checks and a fixed
// multi-cycle access latency reported through a busy/done/error handshake.
module data_mem_sized #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 2
) (
    input logic             clk,
    input logic             reset,
    data_mem_sized_if.slave bus
);
    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
    localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t           state_r, nextState_s;
    logic [2:0]       cnt_r, nextCnt_s;
    logic [IDX_W+1:0] offLat_r;
    logic [31:0]      dataLat_r;
    logic [1:0]       sizeLat_r;
    logic             unsLat_r;
    logic             isWrite_r;
    logic             rejPend_r;
    logic [31:0]      memOut_r;
    logic             busy_r, done_r, error_r;
    logic [31:0]      mem_r [DEPTH_WORDS];

    logic [31:0]      offset_s;
    logic             reqValid_s, reject_s, accept_s, fire_s;
    logic [31:0]      rdWord_s, loadVal_s, wrData_s;
    logic [3:0]       laneEn_s;

    // Lane select plus sign/zero extension; the lane offset is the low byte address.
    function automatic logic [31:0] extendLoad(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   extendLoad = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   extendLoad = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: extendLoad = w;
        endcase
    endfunction

    // Offset from base wraps below BASE_ADDR, so one unsigned compare covers both ends.
    assign offset_s   = bus.address - BASE_ADDR;
    assign reqValid_s = bus.read | bus.write;
    assign reject_s   = (bus.read & bus.write)
                      | (bus.size == 2'b11)
                      | ((bus.size == 2'b01) & bus.address[0])
                      | ((bus.size == 2'b10) & (bus.address[1:0] != 2'b00))
                      | (offset_s >= SPAN);
    assign accept_s   = (state_r == IDLE) & reqValid_s;
    assign fire_s     = (state_r == WAIT) & (cnt_r == 3'd0);
    assign rdWord_s   = mem_r[offLat_r[IDX_W+1:2]];
    assign loadVal_s  = extendLoad(rdWord_s, sizeLat_r, offLat_r[1:0], unsLat_r);

    // Next-state and latency counter.
    always_comb begin
        nextState_s = state_r;
        nextCnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (reqValid_s && !reject_s) begin
                    nextState_s = WAIT;
                    nextCnt_s   = CNT_INIT;
                end else begin
                    nextState_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 3'd0) begin
                    nextState_s = IDLE;
                end else begin
                    nextCnt_s = cnt_r - 3'd1;
                end
            end
            default: begin
                nextState_s = IDLE;
                nextCnt_s   = 3'd0;
            end
        endcase
    end

    // Store lane enables and lane-replicated store data.
    always_comb begin
        laneEn_s = 4'b0000;
        wrData_s = dataLat_r;
        case (sizeLat_r)
            2'b00: begin
                laneEn_s = 4'b0001 << offLat_r[1:0];
                wrData_s = {4{dataLat_r[7:0]}};
            end
            2'b01: begin
                laneEn_s = offLat_r[1] ? 4'b1100 : 4'b0011;
                wrData_s = {2{dataLat_r[15:0]}};
            end
            2'b10:   laneEn_s = 4'b1111;
            default: laneEn_s = 4'b0000;
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= nextState_s;
            cnt_r   <= nextCnt_s;
        end
    end

    // Request capture so the bus may change after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            offLat_r  <= '0;
            dataLat_r <= 32'h0000_0000;
            sizeLat_r <= 2'b00;
            unsLat_r  <= 1'b0;
            isWrite_r <= 1'b0;
        end else if (accept_s && !reject_s) begin
            offLat_r  <= offset_s[IDX_W+1:0];
            dataLat_r <= bus.memIn;
            sizeLat_r <= bus.size;
            unsLat_r  <= bus.unsigned_ld;
            isWrite_r <= bus.write;
        end else begin
            offLat_r  <= offLat_r;
            dataLat_r <= dataLat_r;
            sizeLat_r <= sizeLat_r;
            unsLat_r  <= unsLat_r;
            isWrite_r <= isWrite_r;
        end
    end

    // Handshake outputs; a rejection reports one edge after it is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rejPend_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            memOut_r  <= 32'h0000_0000;
        end else begin
            rejPend_r <= accept_s & reject_s;
            busy_r    <= (nextState_s == WAIT);
            done_r    <= fire_s | rejPend_r;
            error_r   <= rejPend_r;
            memOut_r  <= (fire_s && !isWrite_r) ? loadVal_s : memOut_r;
        end
    end

    // Word array is never cleared; a reset during WAIT leaves fire_s low, dropping the store.
    always_ff @(posedge clk) begin
        if (fire_s && isWrite_r) begin
            for (int i = 0; i < 4; i++) begin
                if (laneEn_s[i]) begin
                    mem_r[offLat_r[IDX_W+1:2]][8*i +: 8] <= wrData_s[8*i +: 8];
                end
            end
        end
    end

    assign bus.memOut = memOut_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.error  = error_r;
endmodule

// File: tb/tb_data_mem_sized.sv
// Directed vector bench for data_mem_sized (LATENCY=2, DEPTH_WORDS=256, BASE_ADDR=0).
module tb_data_mem_sized;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    data_mem_sized_if bus();

    data_mem_sized #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .LATENCY(2)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        expErr;
        logic [31:0] expOut;
    } vec_t;

    vec_t vecs[27];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idleBus();
        bus.read = 1'b0; bus.write = 1'b0; bus.size = 2'b10; bus.unsigned_ld = 1'b0;
        bus.address = 32'h0; bus.memIn = 32'h0;
    endtask

    // Issue one request, wait for done, check latency, error, busy, memOut and pulse width.
    task automatic runVec(input string tag, input vec_t v);
        int  lat;
        bit  got;
        bit  sawBusy;
        lat = 0; got = 1'b0; sawBusy = 1'b0;
        @(negedge clk);
        bus.read = v.rd; bus.write = v.wr; bus.size = v.sz; bus.unsigned_ld = v.uns;
        bus.address = v.addr; bus.memIn = v.wdata;
        @(negedge clk);
        idleBus();
        for (int n = 0; n < 20 && !got; n++) begin
            if (bus.done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (bus.busy === 1'b1) sawBusy = 1'b1;
                lat++;
                @(negedge clk);
            end
        end
        chk({tag, " done_seen"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(lat), v.expErr ? 32'd1 : 32'd2);
        chk({tag, " error"}, 32'(bus.error), 32'(v.expErr));
        chk({tag, " busy_seen"}, 32'(sawBusy), 32'(!v.expErr));
        chk({tag, " memOut"}, bus.memOut, v.expOut);
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int   lat;
        bit   got;
        logic [8:0] doneMask;
        vec_t v;

        //            rd    wr    sz     uns   addr          wdata         err   expOut
        vecs[0]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'd16,       32'h12345678, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'd20,       32'h12345678, 1'b0, 32'h00000000};
        vecs[2]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'd16,       32'h0,        1'b0, 32'h12345678};
        vecs[3]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'd21,       32'hAAAAAAEF, 1'b0, 32'h12345678};
        vecs[4]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'd20,       32'h0,        1'b0, 32'h1234EF78};
        vecs[5]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'd24,       32'h00000080, 1'b0, 32'h1234EF78};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'd24,       32'h0,        1'b0, 32'hFFFFFF80};
        vecs[7]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'd24,       32'h0,        1'b0, 32'h00000080};
        vecs[8]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'd17,       32'h0,        1'b1, 32'h00000080};
        vecs[9]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'd18,       32'h0,        1'b1, 32'h00000080};
        vecs[10] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'd16,       32'h0,        1'b1, 32'h00000080};
        vecs[11] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'd16,       32'h0,        1'b1, 32'h00000080};
        vecs[12] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'd1024,     32'h0,        1'b1, 32'h00000080};
        vecs[13] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h00000080};
        vecs[14] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'd20,       32'h0,        1'b0, 32'hFFFFEF78};
        vecs[15] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'd22,       32'h0,        1'b0, 32'h00001234};
        vecs[16] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'd23,       32'h0,        1'b0, 32'h00000012};
        vecs[17] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'd26,       32'h1234A5B6, 1'b0, 32'h00000012};
        vecs[18] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'd26,       32'h0,        1'b0, 32'hFFFFA5B6};
        vecs[19] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'd24,       32'h0,        1'b0, 32'h00000080};
        vecs[20] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'd1020,     32'hCAFEF00D, 1'b0, 32'h00000080};
        vecs[21] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'd1020,     32'h0,        1'b0, 32'hCAFEF00D};
        vecs[22] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'd28,       32'h00000000, 1'b0, 32'hCAFEF00D};
        vecs[23] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'd32,       32'h11112222, 1'b0, 32'hCAFEF00D};
        vecs[24] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'd21,       32'h0,        1'b0, 32'hFFFFFFEF};
        vecs[25] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'd18,       32'h99999999, 1'b1, 32'hFFFFFFEF};
        vecs[26] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'd16,       32'h0,        1'b0, 32'h12345678};

        idleBus();
        #1;
        chk("reset memOut", bus.memOut, 32'h0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset error", 32'(bus.error), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 27; i++) begin
            runVec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset during WAIT drops the store to @28 and produces no done.
        @(negedge clk);
        bus.write = 1'b1; bus.size = 2'b10; bus.address = 32'd28; bus.memIn = 32'hDEADBEEF;
        @(negedge clk);
        idleBus();
        chk("abort busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort busy_in_reset", 32'(bus.busy), 32'd0);
        chk("abort memOut_in_reset", bus.memOut, 32'h0);
        doneMask = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            doneMask[k] = bus.done;
        end
        reset = 1'b0;
        for (int k = 3; k < 7; k++) begin
            @(negedge clk);
            doneMask[k] = bus.done;
        end
        chk("abort no_done", 32'(doneMask), 32'd0);
        v = '{1'b1, 1'b0, 2'b10, 1'b0, 32'd28, 32'h0, 1'b0, 32'h00000000};
        runVec("abort readback", v);

        // Write request while busy is ignored, not queued.
        @(negedge clk);
        bus.read = 1'b1; bus.size = 2'b10; bus.address = 32'd16;
        @(negedge clk);
        bus.read = 1'b0; bus.write = 1'b1; bus.address = 32'd32; bus.memIn = 32'h55555555;
        lat = 0; got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            if (bus.done === 1'b1) begin
                got = 1'b1;
            end else begin
                lat++;
                @(negedge clk);
            end
        end
        idleBus();
        chk("busyign done_seen", 32'(got), 32'd1);
        chk("busyign latency", 32'(lat), 32'd2);
        chk("busyign memOut", bus.memOut, 32'h12345678);
        @(negedge clk);
        chk("busyign not_queued", 32'(bus.busy), 32'd0);
        v = '{1'b1, 1'b0, 2'b10, 1'b0, 32'd32, 32'h0, 1'b0, 32'h11112222};
        runVec("busyign readback", v);

        // Held read request: accepted every LATENCY+1 cycles.
        @(negedge clk);
        bus.read = 1'b1; bus.size = 2'b10; bus.address = 32'd20;
        doneMask = '0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            doneMask[k] = bus.done;
            if (k == 8) idleBus();
        end
        chk("b2b done_pattern", 32'(doneMask), 32'h124);
        chk("b2b memOut", bus.memOut, 32'h1234EF78);
        @(negedge clk);
        @(negedge clk);
        chk("b2b idle_after", 32'({bus.busy, bus.done}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
